// File: rtl/osd_mam_wb_sram.sv
// Wishbone classic-cycle responder backed by a word-addressed on-chip memory.
// A sampled request is answered with ack/err after WAIT_STATES extra cycles.
//
//  state  | meaning
//  S_IDLE | waiting for cyc_i & stb_i; samples the request
//  S_WAIT | counting down wait states; request must stay asserted
//  S_RESP | one-cycle ack_o/err_o pulse; stb_i is not sampled
module osd_mam_wb_sram #(
   parameter int                    DATA_WIDTH  = 16,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    MEM_WORDS   = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_STATES = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cyc_i,
   input  logic                    stb_i,
   input  logic                    we_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   dat_i,
   input  logic [DATA_WIDTH/8-1:0] sel_i,
   input  logic [2:0]              cti_i,
   input  logic [1:0]              bte_i,
   output logic [DATA_WIDTH-1:0]   dat_o,
   output logic                    ack_o,
   output logic                    err_o
);

   localparam int SW = DATA_WIDTH / 8;
   localparam int OB = $clog2(SW);
   localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [ADDR_WIDTH-1:0] LP_MASK  = ADDR_WIDTH'(SW - 1);
   localparam logic [ADDR_WIDTH-1:0] LP_WORDS = ADDR_WIDTH'(MEM_WORDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [3:0]            r_cnt;
   logic                  r_we;
   logic                  r_bad;
   logic [IW-1:0]         r_idx;
   logic [DATA_WIDTH-1:0] r_wdat;
   logic [SW-1:0]         r_sel;
   logic                  r_ack;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_dat;
   logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

   logic                  w_req;
   logic [ADDR_WIDTH-1:0] w_off;
   logic [ADDR_WIDTH-1:0] w_idx_full;
   logic                  w_bad;
   logic                  w_commit;
   logic                  w_c_we;
   logic                  w_c_bad;
   logic [IW-1:0]         w_c_idx;
   logic [DATA_WIDTH-1:0] w_c_wdat;
   logic [SW-1:0]         w_c_sel;
   logic                  w_unused;

   assign w_unused   = ^{cti_i, bte_i};
   assign w_req      = cyc_i & stb_i;
   assign w_off      = addr_i - BASE_ADDR;
   assign w_idx_full = w_off >> OB;
   assign w_bad      = (|(w_off & LP_MASK)) || (w_idx_full >= LP_WORDS);

   // With zero wait states the commit happens on the sampling edge itself,
   // so the live bus values are used instead of the latched copies.
   assign w_c_we   = (r_state == S_IDLE) ? we_i               : r_we;
   assign w_c_bad  = (r_state == S_IDLE) ? w_bad              : r_bad;
   assign w_c_idx  = (r_state == S_IDLE) ? w_idx_full[IW-1:0] : r_idx;
   assign w_c_wdat = (r_state == S_IDLE) ? dat_i              : r_wdat;
   assign w_c_sel  = (r_state == S_IDLE) ? sel_i              : r_sel;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_req) w_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
         S_WAIT: begin
            if (!w_req)
               w_next = S_IDLE;
            else if (r_cnt == 4'd1)
               w_next = S_RESP;
         end
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_commit = (w_next == S_RESP) && (r_state != S_RESP) && !rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_bad   <= 1'b0;
         r_idx   <= '0;
         r_wdat  <= '0;
         r_sel   <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_dat   <= '0;
      end else begin
         r_state <= w_next;
         r_ack   <= w_commit && !w_c_bad;
         r_err   <= w_commit && w_c_bad;
         if (r_state == S_IDLE && w_req) begin
            r_we   <= we_i;
            r_bad  <= w_bad;
            r_idx  <= w_idx_full[IW-1:0];
            r_wdat <= dat_i;
            r_sel  <= sel_i;
            r_cnt  <= 4'(WAIT_STATES);
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_commit && !w_c_we && !w_c_bad)
            r_dat <= r_mem[w_c_idx];
      end
   end

   // Memory array carries no reset.
   always_ff @(posedge clk_i) begin
      if (w_commit && w_c_we && !w_c_bad) begin
         for (int b = 0; b < SW; b++) begin
            if (w_c_sel[b])
               r_mem[w_c_idx][8*b +: 8] <= w_c_wdat[8*b +: 8];
         end
      end
   end

   assign dat_o = r_dat;
   assign ack_o = r_ack;
   assign err_o = r_err;

endmodule

// File: tb/tb_osd_mam_wb_sram.sv
// Directed bench for osd_mam_wb_sram: three instances cover the default map,
// a non-zero base address and a three-wait-state configuration.
module tb_osd_mam_wb_sram;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  cyc = 3'b000;
   logic [2:0]  stb = 3'b000;
   logic        we = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [15:0] wdat = 16'h0;
   logic [1:0]  sel = 2'b11;
   logic [2:0]  cti = 3'b000;
   logic [1:0]  bte = 2'b00;
   logic [15:0] dout [3];
   logic [2:0]  ack;
   logic [2:0]  err;

   int total = 0;
   int bad = 0;
   int viol = 0;
   logic [2:0] prev_resp = 3'b000;

   always #5 clk = ~clk;

   osd_mam_wb_sram u0 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we),
      .addr_i(addr), .dat_i(wdat), .sel_i(sel), .cti_i(cti), .bte_i(bte),
      .dat_o(dout[0]), .ack_o(ack[0]), .err_o(err[0]));

   osd_mam_wb_sram #(.BASE_ADDR(32'h100)) u1 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we),
      .addr_i(addr), .dat_i(wdat), .sel_i(sel), .cti_i(cti), .bte_i(bte),
      .dat_o(dout[1]), .ack_o(ack[1]), .err_o(err[1]));

   osd_mam_wb_sram #(.WAIT_STATES(3)) u2 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we),
      .addr_i(addr), .dat_i(wdat), .sel_i(sel), .cti_i(cti), .bte_i(bte),
      .dat_o(dout[2]), .ack_o(ack[2]), .err_o(err[2]));

   // Protocol watchdog: ack/err never together, never two cycles in a row.
   always @(negedge clk) begin
      if (!rst) begin
         for (int u = 0; u < 3; u++) begin
            if (ack[u] && err[u]) viol++;
            if ((ack[u] || err[u]) && prev_resp[u]) viol++;
         end
      end
      prev_resp <= ack | err;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Single classic access; returns cycles from sampling edge to response.
   task automatic access(input int u, input logic w, input logic [31:0] a,
                         input logic [15:0] d, input logic [1:0] s,
                         output int n, output logic ak, output logic er);
      we = w; addr = a; wdat = d; sel = s;
      cyc[u] = 1'b1; stb[u] = 1'b1;
      n = 0; ak = 1'b0; er = 1'b0;
      while (n < 20 && !ak && !er) begin
         @(posedge clk); #1;
         n++;
         ak = ack[u]; er = err[u];
      end
      cyc[u] = 1'b0; stb[u] = 1'b0;
      @(posedge clk); #1;
   endtask

   // Back-to-back beats on u0 with the strobe held; master advances on ack.
   task automatic burst(input logic w, input logic [31:0] a0, input int beats);
      int n;
      logic got;
      we = w; sel = 2'b11;
      cyc[0] = 1'b1; stb[0] = 1'b1;
      for (int k = 0; k < beats; k++) begin
         addr = a0 + 32'(2 * k);
         wdat = 16'(k + 1);
         n = 0; got = 1'b0;
         while (n < 10 && !got) begin
            @(posedge clk); #1;
            n++;
            got = ack[0];
         end
         check($sformatf("burst_%s_beat%0d_cycles", w ? "wr" : "rd", k), 32'(n), (k == 0) ? 32'd1 : 32'd2);
         if (!w) check($sformatf("burst_rd_beat%0d_data", k), 32'(dout[0]), 32'(k + 1));
      end
      cyc[0] = 1'b0; stb[0] = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      logic ak, er;
      logic seen;

      // Reset held two cycles with a write request pending on u0.
      we = 1'b1; addr = 32'h0; wdat = 16'h1111; sel = 2'b11;
      cyc[0] = 1'b1; stb[0] = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check("rst_ack", 32'(ack[0]), 32'd0);
      check("rst_err", 32'(err[0]), 32'd0);
      check("rst_dout0", 32'(dout[0]), 32'h0);
      check("rst_dout1", 32'(dout[1]), 32'h0);
      check("rst_dout2", 32'(dout[2]), 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("first_ack_after_rst", 32'(ack[0]), 32'd1);
      cyc[0] = 1'b0; stb[0] = 1'b0;
      @(posedge clk); #1;

      // Basic write/read.
      access(0, 1'b1, 32'h4, 16'hBEEF, 2'b11, n, ak, er);
      check("wr_latency", 32'(n), 32'd1);
      check("wr_ack", 32'(ak), 32'd1);
      access(0, 1'b0, 32'h4, 16'h0, 2'b11, n, ak, er);
      check("rd_latency", 32'(n), 32'd1);
      check("rd_data", 32'(dout[0]), 32'hBEEF);

      // Byte strobe merges only lane 0.
      access(0, 1'b1, 32'h4, 16'h1234, 2'b01, n, ak, er);
      check("bytewr_ack", 32'(ak), 32'd1);
      access(0, 1'b0, 32'h4, 16'h0, 2'b11, n, ak, er);
      check("bytewr_data", 32'(dout[0]), 32'hBE34);

      // Misaligned read.
      access(0, 1'b0, 32'h3, 16'h0, 2'b11, n, ak, er);
      check("misalign_err", 32'(er), 32'd1);
      check("misalign_ack", 32'(ak), 32'd0);
      check("misalign_dout", 32'(dout[0]), 32'hBE34);

      // Out-of-range write must not alias into word 0.
      access(0, 1'b1, 32'h800, 16'hDEAD, 2'b11, n, ak, er);
      check("oor_err", 32'(er), 32'd1);
      check("oor_ack", 32'(ak), 32'd0);
      access(0, 1'b0, 32'h0, 16'h0, 2'b11, n, ak, er);
      check("oor_word0", 32'(dout[0]), 32'h1111);

      // Base address 0x100: below base wraps to a huge index.
      access(1, 1'b0, 32'hFE, 16'h0, 2'b11, n, ak, er);
      check("below_base_err", 32'(er), 32'd1);
      access(1, 1'b1, 32'h100, 16'hCAFE, 2'b11, n, ak, er);
      check("base_wr_ack", 32'(ak), 32'd1);
      access(1, 1'b0, 32'h100, 16'h0, 2'b11, n, ak, er);
      check("base_rd_data", 32'(dout[1]), 32'hCAFE);

      // Three wait states.
      access(2, 1'b1, 32'h0, 16'hAAAA, 2'b11, n, ak, er);
      check("ws3_latency", 32'(n), 32'd4);
      check("ws3_ack", 32'(ak), 32'd1);

      // Abort: strobe dropped after two cycles.
      we = 1'b1; addr = 32'h0; wdat = 16'h5555; sel = 2'b11;
      cyc[2] = 1'b1; stb[2] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      cyc[2] = 1'b0; stb[2] = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         seen = seen | ack[2] | err[2];
      end
      check("abort_no_resp", 32'(seen), 32'd0);
      access(2, 1'b0, 32'h0, 16'h0, 2'b11, n, ak, er);
      check("abort_rd_latency", 32'(n), 32'd4);
      check("abort_rd_data", 32'(dout[2]), 32'hAAAA);

      // Back-to-back bursts.
      burst(1'b1, 32'h10, 4);
      burst(1'b0, 32'h10, 4);

      check("protocol_violations", 32'(viol), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
